// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the d_mem line-fill/writeback arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StSettle = 2'd2,
        StWait   = 2'd3
    } dmem_arb_state_t;

    localparam int unsigned DMEM_ARB_DEF_ADDR_W = 11;
    localparam int unsigned DMEM_ARB_DEF_LINE_W = 64;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of per-CPU request/response signals and the shared d_mem port.
// The master modport is the arbiter's view; slave is the CPUs/d_mem side.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_CPU = 2,
    parameter int unsigned ADDR_W  = DMEM_ARB_DEF_ADDR_W,
    parameter int unsigned LINE_W  = DMEM_ARB_DEF_LINE_W
) ();

    logic [NUM_CPU-1:0]        req_re;
    logic [NUM_CPU-1:0]        req_we;
    logic [NUM_CPU*ADDR_W-1:0] req_addr;
    logic [NUM_CPU*LINE_W-1:0] req_wdata;
    logic [NUM_CPU-1:0]        grant;
    logic [NUM_CPU-1:0]        done;
    logic [LINE_W-1:0]         rd_data;
    logic                      busy;
    logic [ADDR_W-1:0]         dmem_addr;
    logic [LINE_W-1:0]         dmem_wdata;
    logic                      dmem_re;
    logic                      dmem_we;
    logic                      dmem_rdy;
    logic [LINE_W-1:0]         dmem_rd_data;

    modport master (
        input  req_re, req_we, req_addr, req_wdata, dmem_rdy, dmem_rd_data,
        output grant, done, rd_data, busy, dmem_addr, dmem_wdata, dmem_re, dmem_we
    );

    modport slave (
        output req_re, req_we, req_addr, req_wdata, dmem_rdy, dmem_rd_data,
        input  grant, done, rd_data, busy, dmem_addr, dmem_wdata, dmem_re, dmem_we
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational rotating picker: first requester after last_i, wrapping.
// With last_i tied to NUM_CPU-1 it is a plain lowest-index priority encoder.
module dmem_rr_pick #(
    parameter int unsigned NUM_CPU = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_CPU)
) (
    input  logic [NUM_CPU-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_CPU-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= NUM_CPU; off++) begin
            cand = IDX_W'((32'(last_i) + off) % NUM_CPU);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// NUM_CPU-way arbiter in front of the shared d_mem; holds grant until rdy returns.
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_CPU = 2,
    parameter int unsigned ADDR_W  = DMEM_ARB_DEF_ADDR_W,
    parameter int unsigned LINE_W  = DMEM_ARB_DEF_LINE_W
) (
    input logic            clk,
    input logic            rst_n,
    dmem_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_CPU);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CPU - 1);

    dmem_arb_state_t    state_q, state_d;
    logic [NUM_CPU-1:0] grant_q, grant_d;
    logic [NUM_CPU-1:0] done_q, done_d;
    logic [LINE_W-1:0]  rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               re_q, re_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               op_we_q, op_we_d;

    logic [NUM_CPU-1:0] req;
    logic [NUM_CPU-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   last_ptr;
    logic               arb_go;

    assign req = bus.req_re | bus.req_we;
    // The done cycle is skipped so the finishing requester can drop its line first.
    assign arb_go = (state_q == StIdle) && bus.dmem_rdy && (done_q == '0) && (|req);

`ifdef DMEM_ARB_RR_EN
    logic [IDX_W-1:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (arb_go) last_d = pick_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= LAST_RST;
        else        last_q <= last_d;
    end

    assign last_ptr = last_q;
`else
    assign last_ptr = LAST_RST;
`endif

    dmem_rr_pick #(
        .NUM_CPU (NUM_CPU),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i  (req),
        .last_i (last_ptr),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        busy_d    = busy_q;
        op_we_d   = op_we_q;
        case (state_q)
            StIdle: begin
                if (arb_go) begin
                    state_d = StIssue;
                    grant_d = pick_gnt;
                    addr_d  = bus.req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[32'(pick_idx) * LINE_W +: LINE_W];
                    // A simultaneous read+write request is treated as a write.
                    op_we_d = bus.req_we[pick_idx];
                    we_d    = bus.req_we[pick_idx];
                    re_d    = ~bus.req_we[pick_idx];
                    busy_d  = 1'b1;
                end
            end
            StIssue:  state_d = StSettle;
            // rdy may still reflect the previous idle state here, so it is not sampled.
            StSettle: state_d = StWait;
            StWait: begin
                if (bus.dmem_rdy) begin
                    state_d = StIdle;
                    done_d  = grant_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    if (!op_we_q) rd_data_d = bus.dmem_rd_data;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            op_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            op_we_q   <= op_we_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_re    = re_q;
    assign bus.dmem_we    = we_q;

endmodule
